regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file: 32 x 32-bit, MIPS-style; the consumer end of the writeback-stage register-write interface.
- Accepts one write per cycle from writeback (wren, waddr, wdata).
- Serves two decode-stage read ports, with an optional same-cycle write-to-read bypass.
- Register 0 reads as zero and ignores writes.

Parameters:
- DATA_W, 32: register width in bits.
- NREGS, 32: number of architectural registers; index width is log2(NREGS) = 5.
- BYPASS_EN, 1: 1 = a read of a register written in the same cycle returns the incoming write data; 0 = it returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rf_wren_i  input  1  write enable, driven from writeback wb_wren_o.
- rf_waddr_i  input  32  write address, driven from writeback wb_waddr_o; only bits [4:0] used, bits [31:5] ignored.
- rf_wdata_i  input  32  write data, driven from writeback wb_wdata_o.
- rf_ren1_i  input  1  read port 1 enable.
- rf_raddr1_i  input  5  read port 1 register index.
- rf_rdata1_o  output  32  read port 1 data.
- rf_ren2_i  input  1  read port 2 enable.
- rf_raddr2_i  input  5  read port 2 register index.
- rf_rdata2_o  output  32  read port 2 data.
- rf_wcnt_o  output  32  count of committed non-zero-register writes (debug/perf).

Behaviour:
- Storage:
  - regs[1..31] are flops.
  - regs[0] is not stored; it is a constant 0.
- Reset:
  - rst_n low asynchronously clears regs[1..31] and rf_wcnt_o to 0.
  - Read outputs are combinational, so during reset they read 0 for any address.
  - Reset assertion mid-write: the write is discarded.
  - The first write is accepted on the first rising edge after rst_n deasserts.
- Write:
  - Condition: rising edge with rf_wren_i=1 and rf_waddr_i[4:0] != 0.
  - Effect: regs[waddr[4:0]] <= rf_wdata_i, and rf_wcnt_o increments by 1.
  - rf_wcnt_o wraps from 0xFFFFFFFF to 0.
  - A write to index 0, or with rf_wren_i=0, changes no state and does not count.
  - Upper address bits are ignored: 0x00000025 writes r5.
- Read, ports 1 and 2 (identical and independent):
  - Fully combinational, zero latency.
  - Priority, highest first:
    - (a) ren=0 -> 0.
    - (b) raddr=0 -> 0.
    - (c) BYPASS_EN=1 and rf_wren_i=1 and rf_waddr_i[4:0]=raddr -> rf_wdata_i.
    - (d) otherwise -> regs[raddr].
  - With BYPASS_EN=0, case (c) returns the old value; the new value is visible from the cycle after the write edge.
  - Both ports may read the same index, and both may hit the bypass at once.
- No handshake, no backpressure: every asserted write commits on its edge.
  - Writeback stall/flush gating is applied upstream, on wren.
- No X propagation: the outputs are defined for every input combination after reset.

Test Plan:
- Reset, then read r1..r31 on both ports with ren=1 -> all 0; rf_wcnt_o=0.
- Write r5=0xDEADBEEF, next cycle read port1 r5 -> 0xDEADBEEF; rf_wcnt_o=1.
- Write r0=0x12345678, read r0 on both ports -> 0; rf_wcnt_o unchanged.
- BYPASS_EN=1: same cycle wren=1, waddr=7, wdata=0xA5A5A5A5, read r7 on both ports -> 0xA5A5A5A5 in that cycle.
  - Repeat with BYPASS_EN=0 -> old r7 value in that cycle, 0xA5A5A5A5 the next cycle.
- waddr=0x00000025, wdata=0x1 -> r5=0x1.
  - ren1=0 with raddr1=5 -> port1 reads 0 while port2 reads r5 = 0x1.
- Write r3=0xFFFF0000, then assert rst_n=0 asynchronously mid-cycle while wren=1 for r3 with wdata=0x11111111.
  - Required: r3 reads 0 immediately; after release, r3 still 0; rf_wcnt_o=0.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file with one writeback
// write port, two combinational decode read ports and an optional
// same-cycle write-to-read bypass. Register 0 is a hardwired zero.
module regfile #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rf_wren_i,
    input  logic [31:0]              rf_waddr_i,
    input  logic [DATA_W-1:0]        rf_wdata_i,
    input  logic                     rf_ren1_i,
    input  logic [$clog2(NREGS)-1:0] rf_raddr1_i,
    output logic [DATA_W-1:0]        rf_rdata1_o,
    input  logic                     rf_ren2_i,
    input  logic [$clog2(NREGS)-1:0] rf_raddr2_i,
    output logic [DATA_W-1:0]        rf_rdata2_o,
    output logic [31:0]              rf_wcnt_o
);

    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned CNT_W = 32;

    // r0 has no storage; only r1..rN-1 are flops
    logic [DATA_W-1:0] regs [1:NREGS-1];

    logic [AW-1:0]     widx;
    logic              wr_hit;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              unused_waddr_hi;

    // Only the low index bits select a register; writes to r0 are dropped
    assign widx            = rf_waddr_i[AW-1:0];
    assign wr_hit          = rf_wren_i && (widx != '0);
    assign unused_waddr_hi = ^rf_waddr_i[31:AW];

    // Register storage: async clear, one committed write per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                if (widx == AW'(i)) begin
                    regs[i] <= rf_wdata_i;
                end
            end
        end
    end

    // Committed-write counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wcnt_o <= '0;
        end else if (wr_hit) begin
            rf_wcnt_o <= rf_wcnt_o + CNT_W'(1);
        end
    end

    // Read ports: disabled/r0/reset -> 0, then bypass, then stored value
    always_comb begin
        stored1     = '0;
        stored2     = '0;
        rf_rdata1_o = '0;
        rf_rdata2_o = '0;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (rf_raddr1_i == AW'(i)) begin
                stored1 = regs[i];
            end
            if (rf_raddr2_i == AW'(i)) begin
                stored2 = regs[i];
            end
        end
        if (rst_n && rf_ren1_i && (rf_raddr1_i != '0)) begin
            if (BYPASS_EN && rf_wren_i && (widx == rf_raddr1_i)) begin
                rf_rdata1_o = rf_wdata_i;
            end else begin
                rf_rdata1_o = stored1;
            end
        end
        if (rst_n && rf_ren2_i && (rf_raddr2_i != '0)) begin
            if (BYPASS_EN && rf_wren_i && (widx == rf_raddr2_i)) begin
                rf_rdata2_o = rf_wdata_i;
            end else begin
                rf_rdata2_o = stored2;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed + randomized check of regfile against an array model,
// with one bypassing and one non-bypassing instance sharing all inputs.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        wren;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ren1;
    logic [4:0]  ra1;
    logic        ren2;
    logic [4:0]  ra2;
    logic [31:0] rd1_b, rd2_b, wcnt_b;
    logic [31:0] rd1_n, rd2_n, wcnt_n;

    // reference state
    logic [31:0] mdl [32];
    logic [31:0] mdl_wcnt;

    int n_checks;
    int n_fail;

    regfile #(.DATA_W(32), .NREGS(32), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf_wren_i(wren), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
        .rf_ren1_i(ren1), .rf_raddr1_i(ra1), .rf_rdata1_o(rd1_b),
        .rf_ren2_i(ren2), .rf_raddr2_i(ra2), .rf_rdata2_o(rd2_b),
        .rf_wcnt_o(wcnt_b)
    );

    regfile #(.DATA_W(32), .NREGS(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rf_wren_i(wren), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
        .rf_ren1_i(ren1), .rf_raddr1_i(ra1), .rf_rdata1_o(rd1_n),
        .rf_ren2_i(ren2), .rf_raddr2_i(ra2), .rf_rdata2_o(rd2_n),
        .rf_wcnt_o(wcnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read value straight from the read-priority rules
    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] ra, input bit byp);
        if (!rst_n || !en || ra == 5'd0) return 32'h0;
        if (byp && wren && waddr[4:0] == ra) return wdata;
        return mdl[ra];
    endfunction

    task automatic check_reads();
        check("p1_byp", rd1_b, exp_rd(ren1, ra1, 1'b1));
        check("p2_byp", rd2_b, exp_rd(ren2, ra2, 1'b1));
        check("p1_nobyp", rd1_n, exp_rd(ren1, ra1, 1'b0));
        check("p2_nobyp", rd2_n, exp_rd(ren2, ra2, 1'b0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_wcnt = 32'h0;
    endtask

    // One cycle: drive at negedge, check reads, commit on posedge, check count
    task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        @(negedge clk);
        wren = we; waddr = wa; wdata = wd;
        ren1 = e1; ra1 = a1; ren2 = e2; ra2 = a2;
        #1;
        check_reads();
        @(posedge clk);
        if (we && wa[4:0] != 5'd0) begin
            mdl[wa[4:0]] = wd;
            mdl_wcnt     = mdl_wcnt + 32'd1;
        end
        #1;
        check("wcnt_byp", wcnt_b, mdl_wcnt);
        check("wcnt_nobyp", wcnt_n, mdl_wcnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n = 1'b0;
        wren = 1'b0; waddr = '0; wdata = '0;
        ren1 = 1'b0; ra1 = '0; ren2 = 1'b0; ra2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset: all registers read zero, count zero
        for (int r = 1; r < 32; r++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'(r), 1'b1, 5'(32 - r));
        end
        check("wcnt_reset", wcnt_b, 32'h0);

        // Basic write then read
        cycle(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        check("r5_val", rd1_b, 32'hDEADBEEF);
        check("wcnt_one", wcnt_b, 32'd1);

        // Write to r0 is ignored and not counted
        cycle(1'b1, 32'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_zero", rd2_b, 32'h0);
        check("wcnt_r0", wcnt_b, 32'd1);

        // Same-cycle bypass on both ports; non-bypass instance sees old value
        cycle(1'b1, 32'd7, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        wren = 1'b1; waddr = 32'd7; wdata = 32'hA5A5A5A5;
        ren1 = 1'b1; ra1 = 5'd7; ren2 = 1'b1; ra2 = 5'd7;
        #1;
        check("byp_p1", rd1_b, 32'hA5A5A5A5);
        check("byp_p2", rd2_b, 32'hA5A5A5A5);
        check("nobyp_old", rd1_n, 32'h0BADF00D);
        @(posedge clk);
        mdl[7] = 32'hA5A5A5A5;
        mdl_wcnt = mdl_wcnt + 32'd1;
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        check("nobyp_new", rd2_n, 32'hA5A5A5A5);

        // Upper address bits ignored; disabled port reads zero
        cycle(1'b1, 32'h00000025, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 32'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);
        check("ren1_off", rd1_b, 32'h0);
        check("r5_alias", rd2_b, 32'h1);

        // Randomized traffic, reads biased towards the write index
        for (int n = 0; n < 400; n++) begin
            logic [31:0] wa;
            logic [4:0]  a1, a2;
            wa = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa[4:0] : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa[4:0] : 5'($urandom);
            cycle(1'($urandom), wa, $urandom, 1'($urandom_range(0, 7) != 0), a1,
                  1'($urandom_range(0, 7) != 0), a2);
        end

        // Async reset during a write: write is discarded, reads go to zero
        cycle(1'b1, 32'd3, 32'hFFFF0000, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        wren = 1'b1; waddr = 32'd3; wdata = 32'h11111111;
        ren1 = 1'b1; ra1 = 5'd3; ren2 = 1'b1; ra2 = 5'd3;
        #1;
        check("pre_rst_byp", rd1_b, 32'h11111111);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_r3_p1", rd1_b, 32'h0);
        check("rst_r3_p2", rd2_n, 32'h0);
        check("rst_wcnt", wcnt_b, 32'h0);
        @(posedge clk);
        #1;
        check_reads();
        @(negedge clk);
        wren = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("post_rst_r3", rd1_b, 32'h0);
        check("post_rst_wcnt", wcnt_n, 32'h0);

        // First write after reset release is accepted
        cycle(1'b1, 32'd3, 32'h22222222, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("first_wr", rd1_n, 32'h22222222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
